// File: rtl/seven_seg_scan_driver_if.sv
// Digit data and display pins of the multiplexed 7-segment scan driver.
// The producer of digit data holds the master modport; the driver holds the slave modport.
interface seven_seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic [DIGITS-1:0]     blink;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp_out;
    logic                  frame_done;

    modport master (
        output load, value, dp, blank, blink,
        input  an, seg, dp_out, frame_done
    );

    modport slave (
        input  load, value, dp, blank, blink,
        output an, seg, dp_out, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with guard blanking, per-digit
// blank/dp/blink, and frame-synchronous data update so a frame never tears.
module seven_seg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_driver_if.slave bus
);
    localparam int SW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int VW = 4 * DIGITS;

    function automatic logic [6:0] decode_hex(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [SW-1:0]     slot_cnt;
    logic [IW-1:0]     idx;
    logic [FW-1:0]     frame_cnt;
    logic              phase;
    logic              pending;

    logic [VW-1:0]     value_act, value_pnd;
    logic [DIGITS-1:0] dp_act, dp_pnd;
    logic [DIGITS-1:0] blank_act, blank_pnd;
    logic [DIGITS-1:0] blink_act, blink_pnd;

    logic [DIGITS-1:0] an_p1;
    logic [6:0]        seg_p1;
    logic              dp_out_p1;
    logic              frame_done_p1;

    logic              slot_wrap;
    logic              boundary;
    logic              frame_wrap;

    assign slot_wrap  = (slot_cnt == SW'(REFRESH_DIV - 1));
    assign boundary   = slot_wrap && (idx == IW'(DIGITS - 1));
    assign frame_wrap = (frame_cnt == FW'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt  <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (slot_wrap) begin
                slot_cnt <= '0;
                idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
            if (boundary) begin
                if (frame_wrap) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    // A load landing on the boundary itself bypasses pending and wins over it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= 1'b0;
            value_act <= '0;
            dp_act    <= '0;
            blank_act <= '1;
            blink_act <= '0;
            value_pnd <= '0;
            dp_pnd    <= '0;
            blank_pnd <= '1;
            blink_pnd <= '0;
        end else if (boundary) begin
            pending <= 1'b0;
            if (bus.load) begin
                value_act <= bus.value;
                dp_act    <= bus.dp;
                blank_act <= bus.blank;
                blink_act <= bus.blink;
            end else if (pending) begin
                value_act <= value_pnd;
                dp_act    <= dp_pnd;
                blank_act <= blank_pnd;
                blink_act <= blink_pnd;
            end
        end else if (bus.load) begin
            pending   <= 1'b1;
            value_pnd <= bus.value;
            dp_pnd    <= bus.dp;
            blank_pnd <= bus.blank;
            blink_pnd <= bus.blink;
        end
    end

    logic [DIGITS-1:0] an_nxt;
    logic [6:0]        seg_nxt;
    logic              dp_out_nxt;
    logic              guard;
    logic              hidden;
    logic [3:0]        nibble;

    always_comb begin
        an_nxt     = '1;
        seg_nxt    = 7'h7F;
        dp_out_nxt = 1'b1;
        nibble     = value_act[int'(idx) * 4 +: 4];
        guard      = (slot_cnt < SW'(BLANK_CYCLES));
        hidden     = blank_act[idx] | (blink_act[idx] & phase);
        if (!guard && !hidden) begin
            an_nxt     = ~(DIGITS'(1) << idx);
            seg_nxt    = decode_hex(nibble);
            dp_out_nxt = ~dp_act[idx];
        end
    end

    // Output register stage: p0 is the combinational slot decode above, p1 drives the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_p1         <= '1;
            seg_p1        <= 7'h7F;
            dp_out_p1     <= 1'b1;
            frame_done_p1 <= 1'b0;
        end else begin
            an_p1         <= an_nxt;
            seg_p1        <= seg_nxt;
            dp_out_p1     <= dp_out_nxt;
            frame_done_p1 <= boundary;
        end
    end

    assign bus.an         = an_p1;
    assign bus.seg        = seg_p1;
    assign bus.dp_out     = dp_out_p1;
    assign bus.frame_done = frame_done_p1;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed, table-driven bench for seven_seg_scan_driver with DIGITS=4,
// REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_DIV=2 (a frame is 32 cycles).
module tb_seven_seg_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_driver_if #(.DIGITS(4)) bus();

    seven_seg_scan_driver #(
        .DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLINK_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
        int          digit;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        bus.load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] bl, input logic [3:0] bk);
        bus.value = v;
        bus.dp    = d;
        bus.blank = bl;
        bus.blink = bk;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, " frame_done timeout"}, 32'(seen), 32'd1);
    endtask

    // Called at the negedge where frame_done is high; skips whole slots, then checks one slot.
    task automatic check_slot(input int skip, input logic [3:0] an, input logic [6:0] seg,
                              input logic dpo, input string name);
        repeat (8 * skip) tick();
        for (int s = 0; s < 8; s++) begin
            tick();
            if (s < 2)
                check({name, " guard"}, {bus.an, bus.seg, bus.dp_out}, {4'hF, 7'h7F, 1'b1});
            else
                check(name, {bus.an, bus.seg, bus.dp_out}, {an, seg, dpo});
        end
    endtask

    initial begin
        logic [3:0] prev_lit;
        int         lit_onsets;
        int         off_run;
        int         found_at;
        bit         blink_lit[5];

        vecs[0]  = '{16'h3A10, 4'b0100, 4'h0, 4'h0, 0, 4'hE, 7'h40, 1'b1};
        vecs[1]  = '{16'h3A10, 4'b0100, 4'h0, 4'h0, 1, 4'hD, 7'h79, 1'b1};
        vecs[2]  = '{16'h3A10, 4'b0100, 4'h0, 4'h0, 2, 4'hB, 7'h08, 1'b0};
        vecs[3]  = '{16'h3A10, 4'b0100, 4'h0, 4'h0, 3, 4'h7, 7'h30, 1'b1};
        vecs[4]  = '{16'hFEDB, 4'b1001, 4'h0, 4'h0, 0, 4'hE, 7'h03, 1'b0};
        vecs[5]  = '{16'hFEDB, 4'b1001, 4'h0, 4'h0, 1, 4'hD, 7'h21, 1'b1};
        vecs[6]  = '{16'hFEDB, 4'b1001, 4'h0, 4'h0, 2, 4'hB, 7'h06, 1'b1};
        vecs[7]  = '{16'hFEDB, 4'b1001, 4'h0, 4'h0, 3, 4'h7, 7'h0E, 1'b0};
        vecs[8]  = '{16'h7654, 4'b0000, 4'h0, 4'h0, 0, 4'hE, 7'h19, 1'b1};
        vecs[9]  = '{16'h7654, 4'b0000, 4'h0, 4'h0, 1, 4'hD, 7'h12, 1'b1};
        vecs[10] = '{16'h7654, 4'b0000, 4'h0, 4'h0, 2, 4'hB, 7'h02, 1'b1};
        vecs[11] = '{16'h7654, 4'b0000, 4'h0, 4'h0, 3, 4'h7, 7'h78, 1'b1};
        vecs[12] = '{16'h9898, 4'b0000, 4'b0010, 4'h0, 1, 4'hF, 7'h7F, 1'b1};
        vecs[13] = '{16'h9898, 4'b0000, 4'b0010, 4'h0, 0, 4'hE, 7'h00, 1'b1};
        vecs[14] = '{16'h9898, 4'b0000, 4'b0010, 4'h0, 3, 4'h7, 7'h10, 1'b1};
        vecs[15] = '{16'h00C0, 4'b0000, 4'h0, 4'h0, 1, 4'hD, 7'h46, 1'b1};
        vecs[16] = '{16'h1234, 4'b1111, 4'hF, 4'h0, 2, 4'hF, 7'h7F, 1'b1};

        blink_lit = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        bus.load  = 1'b0;
        bus.value = '0;
        bus.dp    = '0;
        bus.blank = '0;
        bus.blink = '0;

        // Idle after reset: dark display, frame_done every 32 cycles.
        apply_reset();
        check("reset outputs", {bus.an, bus.seg, bus.dp_out, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        for (int t = 1; t <= 100; t++) begin
            tick();
            check("idle dark", {bus.an, bus.seg, bus.dp_out}, {4'hF, 7'h7F, 1'b1});
            check("idle frame_done", 32'(bus.frame_done), 32'((t % 32) == 0));
        end

        // Decode, dp, blank and per-slot timing from the vector table.
        for (int i = 0; i < 17; i++) begin
            do_load(vecs[i].value, vecs[i].dp, vecs[i].blank, vecs[i].blink);
            wait_frame("vec");
            check_slot(vecs[i].digit, vecs[i].an, vecs[i].seg, vecs[i].dpo, $sformatf("vec%0d", i));
        end

        // Two loads in one frame: only the later one is shown.
        wait_frame("ab sync");
        do_load(16'h1111, 4'h0, 4'h0, 4'h0);
        repeat (4) tick();
        do_load(16'h2222, 4'h0, 4'h0, 4'h0);
        wait_frame("ab");
        check_slot(0, 4'hE, 7'h24, 1'b1, "ab d0");
        check_slot(0, 4'hD, 7'h24, 1'b1, "ab d1");

        // Load in the boundary cycle beats older pending data and takes effect next slot.
        wait_frame("bnd sync");
        do_load(16'h5555, 4'h0, 4'h0, 4'h0);
        repeat (30) tick();
        bus.value = 16'h6666;
        bus.dp    = 4'h0;
        bus.blank = 4'h0;
        bus.blink = 4'h0;
        bus.load  = 1'b1;
        tick();
        check("bnd frame_done", 32'(bus.frame_done), 32'd1);
        bus.load = 1'b0;
        check_slot(0, 4'hE, 7'h02, 1'b1, "bnd d0");
        wait_frame("bnd next");
        check_slot(0, 4'hE, 7'h02, 1'b1, "bnd persist");

        // Asynchronous reset with digit2 lit, then restart from digit0 slot 0.
        wait_frame("rst sync");
        repeat (20) tick();
        check("pre-reset digit2", {bus.an, bus.seg}, {4'hB, 7'h02});
        #2 rst = 1'b0;
        #1 check("async reset", {bus.an, bus.seg, bus.dp_out, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        found_at = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("post-reset dark", 32'(bus.an), 32'hF);
            if (bus.frame_done === 1'b1) begin
                found_at = k;
                break;
            end
        end
        check("post-reset first frame_done", 32'(found_at), 32'd32);

        // Blink on digit0: phase toggles every 2 frames counted from reset.
        apply_reset();
        do_load(16'h0008, 4'h0, 4'h0, 4'b0001);
        for (int f = 0; f < 5; f++) begin
            wait_frame("blink");
            if (blink_lit[f])
                check_slot(0, 4'hE, 7'h00, 1'b1, $sformatf("blink f%0d d0", f + 1));
            else
                check_slot(0, 4'hF, 7'h7F, 1'b1, $sformatf("blink f%0d d0", f + 1));
            check_slot(0, 4'hD, 7'h40, 1'b1, $sformatf("blink f%0d d1", f + 1));
        end

        do_load(16'h0008, 4'h0, 4'hF, 4'h0);
        wait_frame("blank all");
        for (int c = 0; c < 32; c++) begin
            tick();
            check("blank all", 32'(bus.an), 32'hF);
        end

        // Ten frames: never two anodes low, and guard gaps at every slot change.
        do_load(16'h1234, 4'h0, 4'h0, 4'h0);
        wait_frame("excl");
        prev_lit   = 4'hF;
        lit_onsets = 0;
        off_run    = 0;
        for (int c = 0; c < 320; c++) begin
            tick();
            check("one anode", 32'($countones(~bus.an) <= 1), 32'd1);
            if (bus.an == 4'hF) begin
                off_run++;
            end else begin
                if (bus.an != prev_lit) begin
                    lit_onsets++;
                    if (prev_lit != 4'hF)
                        check("guard gap", 32'(off_run), 32'(off_run >= 2 ? off_run : 2));
                    prev_lit = bus.an;
                end
                off_run = 0;
            end
        end
        check("slot count", 32'(lit_onsets), 32'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
